// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the RV64M multiply/divide sequencer.
//   XLEN        operand/result width (64; W forms use the low 32-bit half)
//   MDU_*       op codes, equal to the instruction funct3 field
//   state_e     sequencer states
//   step_mode_e selects shift-add multiply or restoring divide in mdu_step
//   N_DW / N_W  iteration counts for 64-bit and word operations
package mdu_pkg;

  localparam int XLEN = 64;
  localparam int N_DW = 64;
  localparam int N_W  = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

  // Conditional two's-complement negation.
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
//   i_mode  STEP_MUL (shift-add) or STEP_DIV (restoring)
//   i_acc   {hi[XLEN:0], lo[XLEN-1:0]} working register
//   i_opnd  multiplicand / divisor magnitude
//   o_acc   next working register (divide: quotient bit slot left at 0)
//   o_qbit  quotient bit produced by this divide step (0 for multiply)
module mdu_step
  import mdu_pkg::*;
(
  input  step_mode_e          i_mode,
  input  logic [2*XLEN:0]     i_acc,
  input  logic [XLEN-1:0]     i_opnd,
  output logic [2*XLEN:0]     o_acc,
  output logic                o_qbit
);

  logic [XLEN:0]   w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_fits;

  assign w_hi = i_acc[2*XLEN:XLEN];
  assign w_lo = i_acc[XLEN-1:0];

  // hi stays below 2^XLEN between steps, so the add cannot overflow XLEN+1 bits.
  assign w_sum   = w_hi + (w_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
  assign w_shift = {w_hi[XLEN-1:0], w_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, i_opnd};
  // Partial remainder is always < 2*divisor, so the trial sign bit is exact.
  assign w_fits  = ~w_trial[XLEN];

  always_comb begin
    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_mode == STEP_DIV) begin
      o_qbit = w_fits;
      o_acc  = {(w_fits ? w_trial : w_shift), w_lo[XLEN-2:0], 1'b0};
    end else begin
      o_acc  = {1'b0, w_sum, w_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV64M multiply/divide sequencer.
//   clk, rst            clock (rising edge), async active-high reset
//   valid_i / ready_o   op issue handshake (op_i = funct3, word_i = W form)
//   rs1_i, rs2_i        operands (multiplicand/multiplier, dividend/divisor)
//   flush_i             abort any in-flight op, back to IDLE next edge
//   valid_o / ready_i   result handshake; result_o stable while valid_o
//   busy_o              high whenever the sequencer is not IDLE
module mdu_seq #(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  import mdu_pkg::*;

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(N_DW);

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_word;
  logic [CW-1:0]   r_cnt;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo, r_b;
  logic            r_neg_q, r_neg_r;
  logic [XLEN-1:0] r_result;

  logic            w_accept, w_is_div, w_special;
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
  logic [2*XLEN:0] w_step_acc;
  logic            w_step_qbit;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_sel, w_fix_result;

  assign ready_o  = (r_state == S_IDLE) & ~rst;
  assign valid_o  = (r_state == S_DONE);
  assign busy_o   = (r_state != S_IDLE);
  assign result_o = r_result;
  assign w_accept = valid_i & ready_o;
  assign w_is_div = r_op[2];

  // ---- PREP: operand extension, magnitudes, special cases ----
  assign w_a_signed = r_op[2] ? ~r_op[0] : (r_op == MDU_MULH || r_op == MDU_MULHSU);
  assign w_b_signed = r_op[2] ? ~r_op[0] : (r_op == MDU_MULH);
  assign w_a_ext = r_word ? {{HW{w_a_signed & r_lo[HW-1]}}, r_lo[HW-1:0]} : r_lo;
  assign w_b_ext = r_word ? {{HW{w_b_signed & r_b[HW-1]}}, r_b[HW-1:0]} : r_b;
  assign w_a_neg = w_a_signed & w_a_ext[XLEN-1];
  assign w_b_neg = w_b_signed & w_b_ext[XLEN-1];
  assign w_a_mag = neg_if(w_a_neg, w_a_ext);
  assign w_b_mag = neg_if(w_b_neg, w_b_ext);
  assign w_min   = r_word ? {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0    = w_is_div & (w_b_ext == '0);
  assign w_ovf     = w_is_div & w_a_signed & (w_b_ext == '1) & (w_a_ext == w_min);
  assign w_special = w_div0 | w_ovf;

  // ---- CALC: single shared iteration step ----
  mdu_step u_step (
    .i_mode (w_is_div ? STEP_DIV : STEP_MUL),
    .i_acc  ({r_hi, r_lo}),
    .i_opnd (r_b),
    .o_acc  (w_step_acc),
    .o_qbit (w_step_qbit)
  );

  // ---- FIXUP: sign correction and result selection ----
  assign w_prod     = {r_hi[XLEN-1:0], r_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = neg_if(r_neg_q, r_lo);
  assign w_rem_fix  = neg_if(r_neg_r, r_hi[XLEN-1:0]);

  always_comb begin
    w_sel = w_rem_fix;
    case (r_op)
      // Word multiply runs only 32 steps, leaving the product in lo[63:32].
      MDU_MUL:                          w_sel = r_word ? {{HW{1'b0}}, r_lo[XLEN-1:HW]}
                                                       : w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_sel = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                w_sel = w_quo_fix;
      default:                          w_sel = w_rem_fix;
    endcase
    w_fix_result = r_word ? {{HW{w_sel[HW-1]}}, w_sel[HW-1:0]} : w_sel;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = w_special ? S_FIXUP : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE:  if (ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_PREP)
        r_cnt <= r_word ? CW'(N_W - 1) : CW'(N_DW - 1);
      else if (r_state == S_CALC && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (r_state == S_FIXUP && !flush_i)
        r_result <= w_fix_result;
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (w_accept) begin
        // W forms have no high-half multiplies; they degrade to MUL.
        r_op   <= (word_i && op_i != MDU_MUL && !op_i[2]) ? MDU_MUL : op_i;
        r_word <= word_i;
        r_lo   <= rs1_i;
        r_b    <= rs2_i;
      end
      S_PREP: begin
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_b     <= w_b_mag;
        if (w_div0) begin
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_lo    <= '1;
          r_hi    <= {1'b0, w_a_ext};
        end else if (w_ovf) begin
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
          r_lo    <= w_a_ext;
          r_hi    <= '0;
        end else begin
          r_hi <= '0;
          // Word divides start with the dividend in the top half so the
          // quotient fills the low half after 32 steps.
          r_lo <= (w_is_div && r_word) ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
        end
      end
      S_CALC: begin
        r_hi <= w_step_acc[2*XLEN:XLEN];
        r_lo <= w_step_acc[XLEN-1:0] | {{(XLEN-1){1'b0}}, w_step_qbit};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_i = 64'd0;
  logic [63:0] rs2_i = 64'd0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] result_o;
  logic        busy_o;

  int n_pass = 0;
  int n_tot  = 0;

  mdu_seq #(.XLEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .word_i   (word_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Issue one op, count edges from the accepting edge until valid_o, then consume it.
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    op_i = op; word_i = w; rs1_i = a; rs2_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (valid_o !== 1'b1 && lat < 200) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_tot++; if (ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready_o); else n_pass++;
    n_tot++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else n_pass++;
    n_tot++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
    n_tot++; if (result_o !== 64'd0) $display("FAIL reset_result got=%h exp=0", result_o); else n_pass++;
    @(negedge clk); rst = 1'b0;
    #1;
    n_tot++; if (ready_o !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", ready_o); else n_pass++;
  endtask

  task automatic test_div_signed();
    logic [63:0] r; int lat; bit bz;
    run_op(MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg7_2 got=%h exp=fffffffffffffffd", r); else n_pass++;
    n_tot++; if (lat !== 66) $display("FAIL div_latency got=%0d exp=66", lat); else n_pass++;
    run_op(MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rem_neg7_2 got=%h exp=ffffffffffffffff", r); else n_pass++;
    run_op(MDU_DIVU, 1'b0, 64'd100, 64'd7, r, lat, bz);
    n_tot++; if (r !== 64'd14) $display("FAIL divu_100_7 got=%h exp=e", r); else n_pass++;
    run_op(MDU_REMU, 1'b1, 64'd100, 64'd7, r, lat, bz);
    n_tot++; if (r !== 64'd2) $display("FAIL remuw_100_7 got=%h exp=2", r); else n_pass++;
    n_tot++; if (lat !== 34) $display("FAIL remuw_latency got=%0d exp=34", lat); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic [63:0] r; int lat; bit bz;
    run_op(MDU_DIVU, 1'b0, 64'h1234, 64'd0, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divu_by0 got=%h exp=ffffffffffffffff", r); else n_pass++;
    n_tot++; if (lat !== 2) $display("FAIL divu_by0_latency got=%0d exp=2", lat); else n_pass++;
    run_op(MDU_REMU, 1'b0, 64'h1234, 64'd0, r, lat, bz);
    n_tot++; if (r !== 64'h1234) $display("FAIL remu_by0 got=%h exp=1234", r); else n_pass++;
    run_op(MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFF9) $display("FAIL rem_neg_by0 got=%h exp=fffffffffffffff9", r); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] r; int lat; bit bz;
    run_op(MDU_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'h8000_0000_0000_0000) $display("FAIL div_ovf got=%h exp=8000000000000000", r); else n_pass++;
    n_tot++; if (lat !== 2) $display("FAIL div_ovf_latency got=%0d exp=2", lat); else n_pass++;
    run_op(MDU_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'd0) $display("FAIL rem_ovf got=%h exp=0", r); else n_pass++;
    run_op(MDU_DIV, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_8000_0000) $display("FAIL divw_ovf got=%h exp=ffffffff80000000", r); else n_pass++;
    n_tot++; if (lat !== 2) $display("FAIL divw_ovf_latency got=%0d exp=2", lat); else n_pass++;
  endtask

  task automatic test_mul_high();
    logic [63:0] r; int lat; bit bz;
    run_op(MDU_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'd0) $display("FAIL mulh_m1 got=%h exp=0", r); else n_pass++;
    run_op(MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mulhu_max got=%h exp=fffffffffffffffe", r); else n_pass++;
    run_op(MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mulhsu_m1 got=%h exp=ffffffffffffffff", r); else n_pass++;
    run_op(MDU_MUL, 1'b0, 64'h1_0000_0003, 64'h5, r, lat, bz);
    n_tot++; if (r !== 64'h5_0000_000F) $display("FAIL mul_low got=%h exp=50000000f", r); else n_pass++;
    n_tot++; if (lat !== 66) $display("FAIL mul_latency got=%0d exp=66", lat); else n_pass++;
  endtask

  task automatic test_mulw();
    logic [63:0] r; int lat; bit bz;
    run_op(MDU_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mulw got=%h exp=fffffffffffffffe", r); else n_pass++;
    n_tot++; if (lat !== 34) $display("FAIL mulw_latency got=%0d exp=34", lat); else n_pass++;
    n_tot++; if (bz !== 1'b1) $display("FAIL mulw_busy got=%b exp=1", bz); else n_pass++;
    // MULHW is not an RV64 op: it degrades to MULW.
    run_op(MDU_MULH, 1'b1, 64'h3, 64'h4, r, lat, bz);
    n_tot++; if (r !== 64'd12) $display("FAIL mulhw_as_mulw got=%h exp=c", r); else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] held;
    @(negedge clk);
    op_i = MDU_DIVU; word_i = 1'b0; rs1_i = 64'h55; rs2_i = 64'd0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_tot++; if (lat !== 2) $display("FAIL bp_latency got=%0d exp=2", lat); else n_pass++;
    held = result_o;
    n_tot++; if (held !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL bp_result got=%h exp=ffffffffffffffff", held); else n_pass++;
    // valid_i held high in DONE must be ignored.
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tot++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL bp_hold_result%0d got=%h exp=ffffffffffffffff", i, result_o); else n_pass++;
      n_tot++; if (valid_o !== 1'b1) $display("FAIL bp_hold_valid%0d got=%b exp=1", i, valid_o); else n_pass++;
      n_tot++; if (ready_o !== 1'b0) $display("FAIL bp_hold_ready%0d got=%b exp=0", i, ready_o); else n_pass++;
    end
    valid_i = 1'b0;
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    n_tot++; if (ready_o !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", ready_o); else n_pass++;
    n_tot++; if (valid_o !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", valid_o); else n_pass++;
  endtask

  task automatic test_flush();
    logic [63:0] r; int lat; bit bz; int seen;
    run_op(MDU_REMU, 1'b0, 64'hABCD, 64'd0, r, lat, bz);
    @(negedge clk);
    op_i = MDU_DIV; word_i = 1'b0; rs1_i = 64'd1000; rs2_i = 64'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_tot++; if (ready_o !== 1'b1) $display("FAIL flush_ready got=%b exp=1", ready_o); else n_pass++;
    n_tot++; if (busy_o !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy_o); else n_pass++;
    n_tot++; if (valid_o !== 1'b0) $display("FAIL flush_valid got=%b exp=0", valid_o); else n_pass++;
    n_tot++; if (result_o !== 64'hABCD) $display("FAIL flush_result_kept got=%h exp=abcd", result_o); else n_pass++;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (valid_o === 1'b1) seen++;
    end
    n_tot++; if (seen !== 0) $display("FAIL flush_no_valid got=%0d exp=0", seen); else n_pass++;
    run_op(MDU_DIV, 1'b0, 64'd1000, 64'd3, r, lat, bz);
    n_tot++; if (r !== 64'd333) $display("FAIL post_flush_div got=%h exp=14d", r); else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [63:0] r; int lat; bit bz;
    @(negedge clk);
    op_i = MDU_MULHU; word_i = 1'b0; rs1_i = 64'd77; rs2_i = 64'd99; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tot++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy_o); else n_pass++;
    n_tot++; if (ready_o !== 1'b0) $display("FAIL rst_mid_ready got=%b exp=0", ready_o); else n_pass++;
    n_tot++; if (valid_o !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", valid_o); else n_pass++;
    n_tot++; if (result_o !== 64'd0) $display("FAIL rst_mid_result got=%h exp=0", result_o); else n_pass++;
    @(negedge clk); rst = 1'b0;
    #1;
    n_tot++; if (ready_o !== 1'b1) $display("FAIL rst_mid_release_ready got=%b exp=1", ready_o); else n_pass++;
    run_op(MDU_REMU, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd0, r, lat, bz);
    n_tot++; if (r !== 64'hFFFF_FFFF_8000_0001) $display("FAIL post_rst_remuw_by0 got=%h exp=ffffffff80000001", r); else n_pass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_mul_high();
    test_mulw();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer and iterative datapath for the RV64M multiply/divide ops produced by the instruction decoder: mul/mulh/mulhsu/mulhu/div/divu/rem/remu and the W forms.
- Accepts one op via a valid/ready handshake and runs a shift-add multiply or restoring divide over N iterations.
- Applies sign and special-case fixups, then holds the result until the writeback stage consumes it.
- Drives busy_o so the core stalls fetch/commit while an op is in flight.

Parameters:
XLEN, 64, operand/result width; must be 64 (W forms assume 32-bit halves).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
valid_i  in  1  op issue request.
ready_o  out  1  sequencer can accept an op.
op_i  in  3  op code, equal to funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
word_i  in  1  W variant (opcode arithw).
rs1_i  in  XLEN  operand a / dividend.
rs2_i  in  XLEN  operand b / divisor.
flush_i  in  1  synchronous abort.
valid_o  out  1  result available.
ready_i  in  1  consumer accepts result.
result_o  out  XLEN  result, stable while valid_o=1.
busy_o  out  1  state != IDLE.

Behaviour:
- States: IDLE, PREP, CALC, FIXUP, DONE.
- Reset: state=IDLE, valid_o=0, result_o=0, busy_o=0, iteration counter=0. ready_o=0 while rst is high.
- ready_o = (state==IDLE) & !rst. valid_o = (state==DONE).
- IDLE: on valid_i&ready_o, latch op, word, operands -> PREP. valid_i is ignored in every other state.
- PREP (1 cycle):
  - W forms: operands become the low 32 bits, sign-extended for signed ops, zero-extended for unsigned ops.
  - Take magnitudes of signed operands; record result-sign and remainder-sign.
  - Load N = 32 (word) or 64.
  - Divide-by-zero: quotient = all ones, remainder = dividend -> FIXUP, skipping CALC.
  - Signed overflow (most-negative / -1, at 32 or 64 bits): quotient = dividend, remainder = 0 -> FIXUP, skipping CALC.
  - Otherwise -> CALC.
- CALC (exactly N cycles, counter N-1 down to 0):
  - Multiply: one shift-add step per cycle into a 2N-bit product.
  - Divide: one restoring step per cycle (shift, trial subtract, set quotient bit).
  - Counter at 0 -> FIXUP.
- FIXUP (1 cycle):
  - Negate the product/quotient/remainder when its recorded sign requires it.
  - Select the result: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - W forms sign-extend bit 31 of the selected result.
  - word_i=1 with op 1..3 is treated as MUL.
  - Register result_o -> DONE.
- DONE: hold result_o and valid_o; on ready_i -> IDLE. No op is accepted in the same cycle as the DONE->IDLE transition.
- Latency, accepting edge to valid_o high: normal 64-bit = 66 edges; word = 34 edges; special cases = 2 edges.
- flush_i, any non-IDLE state: -> IDLE at the next edge; valid_o=0; result_o keeps its old value. flush_i has priority over ready_i.
- Async rst asserted mid-operation: immediate return to the reset state; the in-flight op is discarded.

Decomposition:
- Package mdu_pkg: XLEN, op code constants (MDU_MUL..MDU_REMU), state enum, N_DW=64, N_W=32.
- One sub-module, mdu_step: combinational single-iteration step. Inputs: mode, accumulator, operand; outputs: next accumulator, quotient bit. Instantiated once inside mdu_seq.

Test Plan:
- DIV rs1=0xFFFF_FFFF_FFFF_FFF9 (-7), rs2=2 -> result 0xFFFF_FFFF_FFFF_FFFD, valid_o 66 edges after accept. REM, same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU rs1=0x1234, rs2=0 -> 0xFFFF_FFFF_FFFF_FFFF after 2 edges. REMU, same operands -> 0x1234.
- DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> 0x8000_0000_0000_0000 after 2 edges; REM -> 0. DIVW rs1=0x1_8000_0000, rs2=-1 -> 0xFFFF_FFFF_8000_0000.
- rs1=rs2=0xFFFF_FFFF_FFFF_FFFF: MULH -> 0; MULHU -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU -> 0xFFFF_FFFF_FFFF_FFFF.
- MULW rs1=0x7FFF_FFFF, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFE, valid_o 34 edges after accept, busy_o high throughout.
- Backpressure, flush, reset:
  - Hold ready_i=0 for 3 cycles in DONE -> result_o stable, ready_o=0.
  - flush_i in CALC -> IDLE next edge, ready_o=1, no valid_o.
  - rst pulse in CALC -> all outputs at reset values immediately.
